// File: rtl/rx_frontend_mux_pkg.sv
`default_nettype none
// rx_frontend_mux_pkg: settings-bus register map, CTRL bit positions,
// the per-DDC routing record and the 16-bit saturation helper.
package rx_frontend_mux_pkg;

   localparam int C_CTRL_OFS         = 0;
   localparam int C_MUX_BASE         = 1;
   localparam int C_CTRL_NUMCHAN_LSB = 16;
   localparam int C_CTRL_CLEAR_BIT   = 30;
   localparam int C_CTRL_COMMIT_BIT  = 31;
   localparam int C_MUX_QSEL_LSB     = 8;
   localparam int C_MUX_QZERO_BIT    = 16;
   localparam int C_MUX_QNEG_BIT     = 17;

   typedef struct packed {
      logic       q_neg;
      logic       q_zero;
      logic [3:0] q_sel;
      logic [3:0] i_sel;
   } mux_cfg_t;

   // DCO registers follow the MUX block, so their base depends on NUM_DDC.
   function automatic int dco_base(input int num_ddc);
      return C_MUX_BASE + num_ddc;
   endfunction

   function automatic logic [15:0] sat16(input logic [16:0] v);
      if (v[16] != v[15]) begin
         return v[16] ? 16'h8000 : 16'h7FFF;
      end
      return v[15:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/rx_dc_corr.sv
`default_nettype none
// rx_dc_corr: one ADC channel - left-justify to 16 bits, subtract the DC
// estimate held in a 32-bit integrator, register the saturated result.
module rx_dc_corr
   import rx_frontend_mux_pkg::*;
#(
   parameter int ADC_WIDTH = 12
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [ADC_WIDTH-1:0] sample_i,
   input  logic                 integ_en_i,
   input  logic                 load_i,
   input  logic [15:0]          load_val_i,
   output logic [15:0]          corr_o
);

   logic [15:0] scaled;
   logic [15:0] corr_d, corr_q;
   logic [31:0] acc_d, acc_q;

   assign scaled = {sample_i, {(16-ADC_WIDTH){1'b0}}};

   // A load overrides integration; the integrator wraps rather than saturates.
   always_comb begin
      corr_d = sat16({scaled[15], scaled} - {acc_q[31], acc_q[31:16]});
      acc_d  = acc_q;
      if (load_i) begin
         acc_d = {load_val_i, 16'h0000};
      end else if (integ_en_i) begin
         acc_d = acc_q + {{16{corr_d[15]}}, corr_d};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q  <= '0;
         corr_q <= '0;
      end else begin
         acc_q  <= acc_d;
         corr_q <= corr_d;
      end
   end

   assign corr_o = corr_q;

endmodule
`default_nettype wire

// File: rtl/rx_frontend_mux.sv
`default_nettype none
// rx_frontend_mux: registers NUM_ADC ADC inputs, DC-corrects each channel,
// counts over-range codes and routes any channel to the I/Q of NUM_DDC DDCs.
module rx_frontend_mux
   import rx_frontend_mux_pkg::*;
#(
   parameter int         NUM_ADC   = 4,
   parameter int         ADC_WIDTH = 12,
   parameter int         NUM_DDC   = 4,
   parameter logic [6:0] BASE_ADDR = 7'd40
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [6:0]                   serial_addr,
   input  logic [31:0]                  serial_data,
   input  logic                         serial_strobe,
   input  logic [NUM_ADC*ADC_WIDTH-1:0] adc_in,
   output logic [NUM_DDC*16-1:0]        ddc_i,
   output logic [NUM_DDC*16-1:0]        ddc_q,
   output logic [NUM_ADC*16-1:0]        over_count,
   output logic [3:0]                   rx_numchan
);

   logic [6:0]                   ofs;
   logic                         wr_ctrl, commit, clear;
   logic [NUM_DDC-1:0]           mux_wr;
   logic [NUM_ADC-1:0]           dco_wr;
   logic [NUM_ADC*ADC_WIDTH-1:0] adc_q;
   logic [NUM_ADC-1:0]           dc_en_q;
   logic [3:1]                   numchan_sh_q, numchan_q;
   mux_cfg_t                     mux_sh_q  [NUM_DDC];
   mux_cfg_t                     mux_act_q [NUM_DDC];
   logic [15:0]                  corr      [16];
   logic                         unused_data;

   assign ofs         = serial_addr - BASE_ADDR;
   assign wr_ctrl     = serial_strobe && (ofs == 7'(C_CTRL_OFS));
   assign commit      = wr_ctrl && serial_data[C_CTRL_COMMIT_BIT];
   assign clear       = wr_ctrl && serial_data[C_CTRL_CLEAR_BIT];
   assign rx_numchan  = {numchan_q, 1'b0};
   assign unused_data = ^serial_data[29:20];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         adc_q <= '0;
      end else begin
         adc_q <= adc_in;
      end
   end

   // Commit copies the shadow state as it stood before this CTRL write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dc_en_q      <= '0;
         numchan_sh_q <= '0;
         numchan_q    <= '0;
         for (int d = 0; d < NUM_DDC; d++) begin
            mux_sh_q[d]  <= '0;
            mux_act_q[d] <= '0;
         end
      end else begin
         if (wr_ctrl) begin
            dc_en_q      <= serial_data[NUM_ADC-1:0];
            numchan_sh_q <= serial_data[C_CTRL_NUMCHAN_LSB+1 +: 3];
         end
         if (commit) begin
            numchan_q <= numchan_sh_q;
         end
         for (int d = 0; d < NUM_DDC; d++) begin
            if (commit) begin
               mux_act_q[d] <= mux_sh_q[d];
            end
            if (mux_wr[d]) begin
               mux_sh_q[d].i_sel  <= serial_data[3:0];
               mux_sh_q[d].q_sel  <= serial_data[C_MUX_QSEL_LSB +: 4];
               mux_sh_q[d].q_zero <= serial_data[C_MUX_QZERO_BIT];
               mux_sh_q[d].q_neg  <= serial_data[C_MUX_QNEG_BIT];
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_ADC; k++) begin : g_chan
      logic [ADC_WIDTH-1:0] sample;
      logic                 is_ovr;
      logic [15:0]          cnt_q;

      assign sample    = adc_q[k*ADC_WIDTH +: ADC_WIDTH];
      assign is_ovr    = (sample == {1'b0, {(ADC_WIDTH-1){1'b1}}}) ||
                         (sample == {1'b1, {(ADC_WIDTH-1){1'b0}}});
      assign dco_wr[k] = serial_strobe && (ofs == 7'(dco_base(NUM_DDC) + k));

      rx_dc_corr #(
         .ADC_WIDTH (ADC_WIDTH)
      ) u_dc_corr (
         .clock      (clock),
         .reset      (reset),
         .sample_i   (sample),
         .integ_en_i (enable && dc_en_q[k]),
         .load_i     (dco_wr[k]),
         .load_val_i (serial_data[15:0]),
         .corr_o     (corr[k])
      );

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
         end else if (clear) begin
            cnt_q <= '0;
         end else if (enable && is_ovr && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end

      assign over_count[k*16 +: 16] = cnt_q;
   end

   // Selects beyond the last ADC land on these zero entries.
   for (genvar k = NUM_ADC; k < 16; k++) begin : g_pad
      assign corr[k] = '0;
   end

   for (genvar d = 0; d < NUM_DDC; d++) begin : g_ddc
      logic [15:0] i_d, q_d, q_src, i_q, q_q;

      assign mux_wr[d] = serial_strobe && (ofs == 7'(C_MUX_BASE + d));

      always_comb begin
         i_d   = corr[mux_act_q[d].i_sel];
         q_src = corr[mux_act_q[d].q_sel];
         q_d   = q_src;
         if (mux_act_q[d].q_zero) begin
            q_d = '0;
         end else if (mux_act_q[d].q_neg) begin
            q_d = (q_src == 16'h8000) ? 16'h7FFF : 16'h0000 - q_src;
         end
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            i_q <= '0;
            q_q <= '0;
         end else begin
            i_q <= i_d;
            q_q <= q_d;
         end
      end

      assign ddc_i[d*16 +: 16] = i_q;
      assign ddc_q[d*16 +: 16] = q_q;
   end

endmodule
`default_nettype wire
